// File: rtl/icache_if.sv
// icache_if: fetch-side and refill-side signals between IF, the icache and the memory controller.
interface icache_if;
  logic        rdy;
  logic [31:0] pc_in;
  logic        is_stall_IC;
  logic        jp_wrong;
  logic        ins_flag;
  logic [31:0] ins;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_valid;
  logic [31:0] mem_data;
  modport slave (
    input  rdy, pc_in, is_stall_IC, jp_wrong, mem_valid, mem_data,
    output ins_flag, ins, mem_req, mem_addr
  );
  modport master (
    output rdy, pc_in, is_stall_IC, jp_wrong, mem_valid, mem_data,
    input  ins_flag, ins, mem_req, mem_addr
  );
endinterface

// File: rtl/icache.sv
// icache: direct-mapped 256 x 1-word instruction cache with a single outstanding refill.
module icache (
  input logic     clk,
  input logic     rst,
  icache_if.slave bus
);
  typedef enum logic [1:0] {IDLE, MISS, FILL} state_t;
  state_t      state_q, state_d;
  logic [255:0] valid_q;
  logic [21:0] tag_mem [256];
  logic [31:0] data_mem [256];
  logic        ins_flag_q, ins_flag_d;
  logic [31:0] ins_q, ins_d;
  logic        mem_req_q, mem_req_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        flushed_q, flushed_d;
  logic [7:0]  idx, widx;
  logic        hit, lookup, we, deliver;
  assign idx     = bus.pc_in[9:2];
  assign widx    = mem_addr_q[9:2];
  assign hit     = valid_q[idx] && tag_mem[idx] == bus.pc_in[31:10];
  assign lookup  = state_q != MISS && !bus.jp_wrong && !bus.is_stall_IC;
  assign we      = state_q == MISS && bus.mem_valid;
  // a flush seen at any point of the miss suppresses delivery of the refilled word
  assign deliver = we && !flushed_q && !bus.jp_wrong;
  always_comb begin
    state_d    = we ? (deliver ? FILL : IDLE) :
                 state_q == MISS ? MISS :
                 (lookup && !hit) ? MISS : IDLE;
    ins_flag_d = deliver || (lookup && hit);
    ins_d      = deliver ? bus.mem_data : (lookup && hit) ? data_mem[idx] : ins_q;
    mem_req_d  = state_q == MISS ? !bus.mem_valid : lookup && !hit;
    mem_addr_d = (lookup && !hit) ? {bus.pc_in[31:2], 2'b00} : mem_addr_q;
    flushed_d  = state_q == MISS ? (flushed_q || bus.jp_wrong) : 1'b0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      ins_flag_q <= 1'b0;
      ins_q      <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      flushed_q  <= 1'b0;
    end else if (bus.rdy) begin
      state_q    <= state_d;
      ins_flag_q <= ins_flag_d;
      ins_q      <= ins_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      flushed_q  <= flushed_d;
      if (we) valid_q[widx] <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst && bus.rdy && we) begin
      data_mem[widx] <= bus.mem_data;
      tag_mem[widx]  <= mem_addr_q[31:10];
    end
  end
  assign bus.ins_flag = ins_flag_q;
  assign bus.ins      = ins_q;
  assign bus.mem_req  = mem_req_q;
  assign bus.mem_addr = mem_addr_q;
endmodule
